// File: rtl/dec_scan_seq_if.sv
// Select/strobe bus for the registered scanning decoder.
// The master (control logic) drives enable, mode, select and load; the
// slave (decoder) returns the active-low strobes, the decoded select and
// the scan wrap pulse.
interface dec_scan_seq_if #(
   parameter int SEL_W = 4
);
   logic                    enable_n;
   logic [1:0]              mode;
   logic [SEL_W-1:0]        sel_in;
   logic                    load;
   logic [(2**SEL_W)-1:0]   dec_n;
   logic [SEL_W-1:0]        cur_sel;
   logic                    wrap;

   modport master (
      output enable_n, mode, sel_in, load,
      input  dec_n, cur_sel, wrap
   );

   modport slave (
      input  enable_n, mode, sel_in, load,
      output dec_n, cur_sel, wrap
   );
endinterface

// File: rtl/dec_scan_seq.sv
// Registered SEL_W-to-2**SEL_W active-low decoder with an auto-scan
// sequencer for row/bank strobing.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_DIRECT | cur_sel follows sel_in every edge, dwell counter held at 0
//   ST_UP     | cur_sel steps +1 every DWELL edges, wrap on max -> 0
//   ST_DOWN   | cur_sel steps -1 every DWELL edges, wrap on 0 -> max
//   ST_HOLD   | cur_sel and dwell counter frozen, strobe stays asserted
//
// The state register is the registered copy of the mode input. A change
// of mode is seen as mode != state at an edge; that edge restarts the
// dwell so the first step in a new scan mode is a full DWELL later.
// enable_n high blanks the strobes and freezes everything, including the
// state, so operation resumes exactly where it stopped.
module dec_scan_seq #(
   parameter int SEL_W = 4,
   parameter int DWELL = 1
) (
   input  logic             clk,
   input  logic             reset,
   dec_scan_seq_if.slave    bus
);

   localparam int OUT_W = 2**SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

   generate
      if (SEL_W < 1 || SEL_W > 8) begin : g_bad_sel_w
         $error("dec_scan_seq: SEL_W must be in 1..8");
      end
      if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
         $error("dec_scan_seq: DWELL must be in 1..65535");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_DIRECT = 2'b00,
      ST_UP     = 2'b01,
      ST_DOWN   = 2'b10,
      ST_HOLD   = 2'b11
   } mode_t;

   mode_t             state_q, state_d;
   mode_t             mode_req;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OUT_W-1:0]  dec_q, dec_d;
   logic              wrap_q, wrap_d;
   logic              dwell_done;

   assign mode_req   = mode_t'(bus.mode);
   assign dwell_done = (cnt_q == CNT_MAX);

   // State, select, dwell counter and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_DIRECT;
         sel_q   <= '0;
         cnt_q   <= '0;
         dec_q   <= '1;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next-state, next select/dwell and registered-output decode.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      dec_d   = '1;

      if (!bus.enable_n) begin
         state_d = mode_req;

         if (mode_req == ST_DIRECT) begin
            sel_d = bus.sel_in;
            cnt_d = '0;
         end else if (bus.load) begin
            // Load wins over any advance or wrap due at this edge.
            sel_d = bus.sel_in;
            cnt_d = '0;
         end else if (mode_req != state_q) begin
            cnt_d = '0;
         end else begin
            case (state_q)
               ST_UP: begin
                  if (dwell_done) begin
                     cnt_d  = '0;
                     sel_d  = sel_q + SEL_ONE;
                     wrap_d = (sel_q == SEL_MAX);
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
               ST_DOWN: begin
                  if (dwell_done) begin
                     cnt_d  = '0;
                     sel_d  = sel_q - SEL_ONE;
                     wrap_d = (sel_q == '0);
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
               ST_HOLD: begin
                  sel_d = sel_q;
                  cnt_d = cnt_q;
               end
               default: begin
                  sel_d = bus.sel_in;
                  cnt_d = '0;
               end
            endcase
         end

         dec_d        = '1;
         dec_d[sel_d] = 1'b0;
      end
   end

   assign bus.dec_n   = dec_q;
   assign bus.cur_sel = sel_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Scoreboard bench for dec_scan_seq: two instances (DWELL=3 and DWELL=1),
// stimulus pushes hand-derived expectations, a monitor pops one per edge.
module tb_dec_scan_seq;

   localparam logic [1:0] M_DIR  = 2'b00;
   localparam logic [1:0] M_UP   = 2'b01;
   localparam logic [1:0] M_DOWN = 2'b10;
   localparam logic [1:0] M_HOLD = 2'b11;

   typedef struct {
      string       nm;
      logic [3:0]  sel;
      logic [15:0] dec;
      logic        wrap;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;

   dec_scan_seq_if #(.SEL_W(4)) bus_a ();
   dec_scan_seq_if #(.SEL_W(4)) bus_b ();

   dec_scan_seq #(.SEL_W(4), .DWELL(3)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a.slave)
   );

   dec_scan_seq #(.SEL_W(4), .DWELL(1)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b.slave)
   );

   task automatic cmp(input string who, input exp_t e, input logic [3:0] sel,
                      input logic [15:0] dec, input logic wrap);
      checks++;
      if (sel !== e.sel) begin
         errors++;
         $display("FAIL %s %s cur_sel got %0d expected %0d", who, e.nm, sel, e.sel);
      end
      checks++;
      if (dec !== e.dec) begin
         errors++;
         $display("FAIL %s %s dec_n got %h expected %h", who, e.nm, dec, e.dec);
      end
      checks++;
      if (wrap !== e.wrap) begin
         errors++;
         $display("FAIL %s %s wrap got %b expected %b", who, e.nm, wrap, e.wrap);
      end
   endtask

   // Monitor: one registered result per edge per instance, checked #1 after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp("A", e, bus_a.cur_sel, bus_a.dec_n, bus_a.wrap);
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp("B", e, bus_b.cur_sel, bus_b.dec_n, bus_b.wrap);
         end
      end
   end

   // One edge of stimulus on instance d, with the result expected after it.
   task automatic step(input int d, input logic rst, input logic en_n,
                       input logic [1:0] md, input logic [3:0] si, input logic ld,
                       input logic [3:0] es, input logic act, input logic ew,
                       input string nm);
      exp_t e;
      e.nm   = nm;
      e.sel  = es;
      e.dec  = act ? ~(16'h0001 << es) : 16'hFFFF;
      e.wrap = ew;
      @(negedge clk);
      if (d == 0) begin
         rst_a          = rst;
         bus_a.enable_n = en_n;
         bus_a.mode     = md;
         bus_a.sel_in   = si;
         bus_a.load     = ld;
         qa.push_back(e);
      end else begin
         rst_b          = rst;
         bus_b.enable_n = en_n;
         bus_b.mode     = md;
         bus_b.sel_in   = si;
         bus_b.load     = ld;
         qb.push_back(e);
      end
   endtask

   // Scan-up on A from the mode-change edge: edge k leaves (k-1)/3 mod 16.
   task automatic scan_up_a(input int n, input string nm);
      for (int k = 1; k <= n; k++) begin
         logic [3:0] es;
         logic       ew;
         es = 4'((k - 1) / 3);
         ew = (k > 1) && ((k - 1) % 3 == 0) && (es == 4'd0);
         step(0, 0, 0, M_UP, 4'd0, 0, es, 1, ew, nm);
      end
   endtask

   initial begin
      bus_a.enable_n = 1'b1; bus_a.mode = M_DIR; bus_a.sel_in = '0; bus_a.load = 1'b0;
      bus_b.enable_n = 1'b1; bus_b.mode = M_DIR; bus_b.sel_in = '0; bus_b.load = 1'b0;

      // Reset state.
      step(0, 1, 0, M_UP, 4'd7, 1, 4'd0, 0, 0, "reset");
      step(0, 1, 0, M_DIR, 4'd3, 0, 4'd0, 0, 0, "reset_hold");

      // Direct mode sweep.
      for (int i = 0; i < 16; i++)
         step(0, 0, 0, M_DIR, 4'(i), 0, 4'(i), 1, 0, "direct");
      step(0, 0, 0, M_DIR, 4'd5, 1, 4'd5, 1, 0, "direct_5");
      begin
         exp_t e;
         e.nm = "direct_5_lit"; e.sel = 4'd5; e.dec = 16'hFFDF; e.wrap = 1'b0;
         @(negedge clk);
         qa.push_back(e);
      end
      step(0, 0, 0, M_DIR, 4'd15, 0, 4'd15, 1, 0, "direct_15");

      // Enable off: blanked, select frozen; then resume.
      step(0, 0, 1, M_DIR, 4'd3, 0, 4'd15, 0, 0, "disabled");
      step(0, 0, 1, M_DIR, 4'd7, 0, 4'd15, 0, 0, "disabled");
      step(0, 0, 1, M_DIR, 4'd9, 0, 4'd15, 0, 0, "disabled");
      step(0, 0, 0, M_DIR, 4'd6, 0, 4'd6, 1, 0, "reenable");

      // Scan-up from reset through a full wrap.
      step(0, 1, 0, M_UP, 4'd0, 0, 4'd0, 0, 0, "reset_scan");
      scan_up_a(52, "scan_up");

      // Reset mid-dwell at cur_sel=9, then fresh scan.
      step(0, 1, 0, M_UP, 4'd0, 0, 4'd0, 0, 0, "reset_scan2");
      scan_up_a(29, "scan_up_pre");
      step(0, 1, 0, M_UP, 4'd0, 0, 4'd0, 0, 0, "reset_mid");
      scan_up_a(8, "scan_up_post");

      // Hold at dwell count 1, then back to scan-up.
      step(0, 1, 0, M_UP, 4'd0, 0, 4'd0, 0, 0, "reset_hold_test");
      scan_up_a(5, "scan_pre_hold");
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, M_HOLD, 4'd12, 0, 4'd1, 1, 0, "hold");
      step(0, 0, 0, M_UP, 4'd0, 0, 4'd1, 1, 0, "resume");
      step(0, 0, 0, M_UP, 4'd0, 0, 4'd1, 1, 0, "resume");
      step(0, 0, 0, M_UP, 4'd0, 0, 4'd1, 1, 0, "resume");
      step(0, 0, 0, M_UP, 4'd0, 0, 4'd2, 1, 0, "resume_adv");
      step(0, 0, 0, M_UP, 4'd0, 0, 4'd2, 1, 0, "resume");
      step(0, 0, 0, M_UP, 4'd0, 0, 4'd2, 1, 0, "resume");
      step(0, 0, 0, M_UP, 4'd0, 0, 4'd3, 1, 0, "resume_adv");
      step(0, 1, 0, M_DIR, 4'd0, 0, 4'd0, 0, 0, "park_a");

      // DWELL=1: scan-down with load, wrap, and load over a wrap.
      step(1, 1, 0, M_DIR, 4'd0, 0, 4'd0, 0, 0, "b_reset");
      step(1, 0, 0, M_DOWN, 4'd2, 1, 4'd2, 1, 0, "down_load");
      step(1, 0, 0, M_DOWN, 4'd9, 0, 4'd1, 1, 0, "down");
      step(1, 0, 0, M_DOWN, 4'd9, 0, 4'd0, 1, 0, "down");
      step(1, 0, 0, M_DOWN, 4'd9, 0, 4'd15, 1, 1, "down_wrap");
      step(1, 0, 0, M_DOWN, 4'd9, 0, 4'd14, 1, 0, "down");
      step(1, 0, 0, M_DOWN, 4'd0, 1, 4'd0, 1, 0, "down_load0");
      step(1, 0, 0, M_DOWN, 4'd7, 1, 4'd7, 1, 0, "load_over_wrap");
      step(1, 0, 0, M_DOWN, 4'd0, 0, 4'd6, 1, 0, "down");

      // DWELL=1 scan-up wrap, freeze and resume.
      step(1, 0, 0, M_UP, 4'd15, 1, 4'd15, 1, 0, "up_load");
      step(1, 0, 0, M_UP, 4'd0, 0, 4'd0, 1, 1, "up_wrap");
      step(1, 0, 0, M_UP, 4'd0, 0, 4'd1, 1, 0, "up");
      step(1, 0, 1, M_UP, 4'd8, 1, 4'd1, 0, 0, "up_frozen");
      step(1, 0, 1, M_UP, 4'd8, 1, 4'd1, 0, 0, "up_frozen");
      step(1, 0, 0, M_UP, 4'd8, 0, 4'd2, 1, 0, "up_resume");

      // Hold with load, then hold.
      step(1, 0, 0, M_HOLD, 4'd9, 1, 4'd9, 1, 0, "hold_load");
      step(1, 0, 0, M_HOLD, 4'd4, 0, 4'd9, 1, 0, "hold");
      step(1, 0, 0, M_HOLD, 4'd4, 0, 4'd9, 1, 0, "hold");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++)
         @(negedge clk);
      if (qa.size() > 0 || qb.size() > 0) begin
         errors++;
         $display("FAIL drain queued %0d/%0d expected 0/0", qa.size(), qb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
